// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    // Widest operand supported by the bit_reverse helper.
    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    // Reverses the low 'width' bits of value. The result is zero-extended to MAX_N bits.
    // Callers truncate the result back to their own width.
    function automatic logic [MAX_N-1:0] bit_reverse(input logic [MAX_N-1:0] value,
                                                     input int unsigned width);
        logic [MAX_N-1:0] full;
        for (int i = 0; i < MAX_N; i++) begin
            full[i] = value[MAX_N-1-i];
        end
        return full >> (MAX_N - width);
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One layer of the shift tree and its pipeline register.
// The layer optionally shifts right by 2**STAGE_IDX. The fill bits depend on the operation.
// The stage loads whenever it is empty or its downstream neighbour can take its contents.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int N         = 32,
    parameter int L         = $clog2(N),
    parameter int STAGE_IDX = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            src_valid,
    output logic            src_ready,
    input  logic [N-1:0]    src_data,
    input  logic [L-1:0]    src_shamt,
    input  shift_op_t       src_op,
    input  logic            src_sign,
    input  logic            dst_ready,
    output logic [N-1:0]    layer_data,
    input  logic [N-1:0]    load_data,
    output logic            stage_valid,
    output logic [N-1:0]    stage_data,
    output logic [L-1:0]    stage_shamt,
    output shift_op_t       stage_op,
    output logic            stage_sign
);

    localparam int S = 1 << STAGE_IDX;

    logic [S-1:0] fill;
    logic [N-1:0] shifted;

    logic         valid_reg;
    logic [N-1:0] data_reg;
    logic [L-1:0] shamt_reg;
    shift_op_t    op_reg;
    logic         sign_reg;

    // Select the bits that enter at the top when the word moves right by S.
    always_comb begin
        fill = '0;
        case (src_op)
            SHIFT_SRA: fill = {S{src_sign}};
            SHIFT_ROR: fill = src_data[S-1:0];
            default:   fill = '0;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        if (gi < N - S) begin : g_body
            assign shifted[gi] = src_data[gi + S];
        end else begin : g_fill
            assign shifted[gi] = fill[gi - (N - S)];
        end
    end

    assign layer_data = src_shamt[STAGE_IDX] ? shifted : src_data;

    // An empty stage always accepts, so bubbles collapse even under an output stall.
    assign src_ready = dst_ready || !valid_reg;

    // Load the stage when it can move. Otherwise hold every field.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            shamt_reg <= '0;
            op_reg    <= SHIFT_SLL;
            sign_reg  <= 1'b0;
        end else if (src_ready) begin
            valid_reg <= src_valid;
            data_reg  <= load_data;
            shamt_reg <= src_shamt;
            op_reg    <= src_op;
            sign_reg  <= src_sign;
        end
    end

    assign stage_valid = valid_reg;
    assign stage_data  = data_reg;
    assign stage_shamt = shamt_reg;
    assign stage_op    = op_reg;
    assign stage_sign  = sign_reg;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined N-bit barrel shifter with a valid/ready handshake.
// The shifter has L = log2(N) right-shift layers. Each layer is followed by a register.
// SLL is handled by mirroring the word before the first layer and after the last layer.
// N must be a power of two in the range 2..MAX_N.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic [L-1:0]    in_shamt,
    input  shift_op_t       in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data
);

    // Index k holds the inputs of stage k. Index L holds the outputs of the last stage.
    logic         pipe_valid [0:L];
    logic [N-1:0] pipe_data  [0:L];
    logic [L-1:0] pipe_shamt [0:L];
    shift_op_t    pipe_op    [0:L];
    logic         pipe_sign  [0:L];
    logic         pipe_ready [0:L];

    logic [N-1:0] layer_data [0:L-1];
    logic [N-1:0] load_data  [0:L-1];

    // Entry: mirror SLL operands so the tree only shifts right.
    // Capture the sign bit for SRA before any mirroring.
    assign pipe_valid[0] = in_valid;
    assign pipe_data[0]  = (in_op == SHIFT_SLL) ? N'(bit_reverse(MAX_N'(in_data), N)) : in_data;
    assign pipe_shamt[0] = in_shamt;
    assign pipe_op[0]    = in_op;
    assign pipe_sign[0]  = in_data[N-1];

    assign pipe_ready[L] = out_ready;
    assign in_ready      = pipe_ready[0];

    for (genvar gi = 0; gi < L; gi++) begin : g_stage
        if (gi == L - 1) begin : g_exit
            // Undo the entry mirroring before the final register, so out_data is registered.
            assign load_data[gi] = (pipe_op[gi] == SHIFT_SLL)
                                 ? N'(bit_reverse(MAX_N'(layer_data[gi]), N))
                                 : layer_data[gi];
        end else begin : g_mid
            assign load_data[gi] = layer_data[gi];
        end

        shifter_stage #(
            .N         (N),
            .L         (L),
            .STAGE_IDX (gi)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .src_valid   (pipe_valid[gi]),
            .src_ready   (pipe_ready[gi]),
            .src_data    (pipe_data[gi]),
            .src_shamt   (pipe_shamt[gi]),
            .src_op      (pipe_op[gi]),
            .src_sign    (pipe_sign[gi]),
            .dst_ready   (pipe_ready[gi+1]),
            .layer_data  (layer_data[gi]),
            .load_data   (load_data[gi]),
            .stage_valid (pipe_valid[gi+1]),
            .stage_data  (pipe_data[gi+1]),
            .stage_shamt (pipe_shamt[gi+1]),
            .stage_op    (pipe_op[gi+1]),
            .stage_sign  (pipe_sign[gi+1])
        );
    end

    assign out_valid = pipe_valid[L];
    assign out_data  = pipe_data[L];

    // The control fields of the last stage are not needed past the exit.
    logic unused_tail;
    assign unused_tail = ^{pipe_shamt[L], pipe_op[L], pipe_sign[L]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and table-driven bench for the pipelined barrel shifter.
// The bench covers an N=32 instance and an N=8 instance.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    logic clk;
    logic rst;

    // N=32 instance
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] in_data32, out_data32, exp32;
    logic [4:0]  in_shamt32;
    shift_op_t   in_op32;

    // N=8 instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_data8, out_data8;
    logic [2:0]  in_shamt8;
    shift_op_t   in_op8;

    pipelined_barrel_shifter #(.N(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
        .in_shamt(in_shamt32), .in_op(in_op32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32)
    );

    pipelined_barrel_shifter #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_shamt(in_shamt8), .in_op(in_op8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        shift_op_t   op;
        logic [31:0] expected;
    } vec_t;

    vec_t        vecs [20];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q32 [$];
    logic [7:0]  exp_q8 [$];
    int          in_cnt32 = 0, out_cnt32 = 0, in_cnt8 = 0, out_cnt8 = 0;

    logic [7:0]  r_data8 [64];
    logic [2:0]  r_sh8 [64];
    shift_op_t   r_op8 [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model for the 8-bit instance.
    function automatic logic [7:0] ref8(input logic [7:0] d, input logic [2:0] s, input shift_op_t op);
        logic [15:0] w;
        case (op)
            SHIFT_SLL: return d << s;
            SHIFT_SRL: return d >> s;
            SHIFT_SRA: return 8'($signed(d) >>> s);
            default: begin
                w = {d, d} >> s;
                return w[7:0];
            end
        endcase
    endfunction

    // Scoreboard: sample handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid32 && out_ready32) begin
                out_cnt32++;
                if (exp_q32.size() == 0) begin
                    check("out32_unexpected", 32'd1, 32'd0);
                end else begin
                    $display("[out32] #%0d data=%h expected=%h", out_cnt32, out_data32, exp_q32[0]);
                    check("out32_data", out_data32, exp_q32.pop_front());
                end
            end
            if (in_valid32 && in_ready32) begin
                in_cnt32++;
                exp_q32.push_back(exp32);
            end
            if (out_valid8 && out_ready8) begin
                out_cnt8++;
                if (exp_q8.size() == 0) begin
                    check("out8_unexpected", 32'd1, 32'd0);
                end else begin
                    $display("[out8] #%0d data=%h expected=%h", out_cnt8, out_data8, exp_q8[0]);
                    check("out8_data", {24'd0, out_data8}, {24'd0, exp_q8.pop_front()});
                end
            end
            if (in_valid8 && in_ready8) begin
                in_cnt8++;
                exp_q8.push_back(ref8(in_data8, in_shamt8, in_op8));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input int idx);
        in_valid32 = 1'b1;
        in_data32  = vecs[idx].data;
        in_shamt32 = vecs[idx].shamt;
        in_op32    = vecs[idx].op;
        exp32      = vecs[idx].expected;
    endtask

    task automatic idle32();
        in_valid32 = 1'b0;
    endtask

    task automatic drive8(input int idx);
        in_valid8 = 1'b1;
        in_data8  = r_data8[idx];
        in_shamt8 = r_sh8[idx];
        in_op8    = r_op8[idx];
    endtask

    int          lat, a0, o0, stable_bad, ir_bad, k, idx;
    logic [31:0] held;
    logic        held_set;
    int          oc [$];

    initial begin
        vecs[0]  = '{32'h8000_00F0, 5'd4,  SHIFT_SRA, 32'hF800_000F};
        vecs[1]  = '{32'h0000_0001, 5'd31, SHIFT_SLL, 32'h8000_0000};
        vecs[2]  = '{32'h8000_0000, 5'd31, SHIFT_SRL, 32'h0000_0001};
        vecs[3]  = '{32'h0000_0001, 5'd1,  SHIFT_ROR, 32'h8000_0000};
        vecs[4]  = '{32'h1234_5678, 5'd0,  SHIFT_ROR, 32'h1234_5678};
        vecs[5]  = '{32'h1234_5678, 5'd0,  SHIFT_SLL, 32'h1234_5678};
        vecs[6]  = '{32'h1234_5678, 5'd0,  SHIFT_SRL, 32'h1234_5678};
        vecs[7]  = '{32'h8765_4321, 5'd0,  SHIFT_SRA, 32'h8765_4321};
        vecs[8]  = '{32'h8000_0000, 5'd31, SHIFT_SRA, 32'hFFFF_FFFF};
        vecs[9]  = '{32'h7FFF_FFFF, 5'd31, SHIFT_SRA, 32'h0000_0000};
        vecs[10] = '{32'hFFFF_FFFF, 5'd31, SHIFT_SLL, 32'h8000_0000};
        vecs[11] = '{32'h1234_5678, 5'd4,  SHIFT_SLL, 32'h2345_6780};
        vecs[12] = '{32'h1234_5678, 5'd4,  SHIFT_SRL, 32'h0123_4567};
        vecs[13] = '{32'h1234_5678, 5'd4,  SHIFT_ROR, 32'h8123_4567};
        vecs[14] = '{32'h1234_5678, 5'd16, SHIFT_ROR, 32'h5678_1234};
        vecs[15] = '{32'h8000_0000, 5'd1,  SHIFT_SRA, 32'hC000_0000};
        vecs[16] = '{32'h0000_00FF, 5'd8,  SHIFT_SLL, 32'h0000_FF00};
        vecs[17] = '{32'h8000_0001, 5'd31, SHIFT_ROR, 32'h0000_0003};
        vecs[18] = '{32'hF000_0000, 5'd28, SHIFT_SRL, 32'h0000_000F};
        vecs[19] = '{32'h8000_0001, 5'd1,  SHIFT_SLL, 32'h0000_0002};

        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 8; s++) begin
                for (int r = 0; r < 2; r++) begin
                    idx = o * 16 + s * 2 + r;
                    r_op8[idx]   = shift_op_t'(2'(o));
                    r_sh8[idx]   = 3'(s);
                    r_data8[idx] = 8'($urandom_range(0, 255)) | (r == 1 ? 8'h80 : 8'h00);
                end
            end
        end

        rst = 1'b0;
        in_valid32 = 1'b0; in_data32 = '0; in_shamt32 = '0; in_op32 = SHIFT_SLL; exp32 = '0;
        out_ready32 = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_op8 = SHIFT_SLL; out_ready8 = 1'b1;

        // Reset held for 3 cycles
        repeat (3) tick();
        check("rst_out_valid_during", {31'd0, out_valid32}, 32'd0);
        rst = 1'b1;
        tick();
        check("rst_out_valid", {31'd0, out_valid32}, 32'd0);
        check("rst_out_data", out_data32, 32'd0);
        check("rst_in_ready", {31'd0, in_ready32}, 32'd1);

        // Latency of a single SRA request
        drive32(0);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            idle32();
            if (out_valid32 && lat < 0) lat = c;
        end
        check("latency", lat, 32'd5);

        // Four back-to-back requests must emerge on four consecutive cycles
        oc.delete();
        for (int c = 0; c < 20; c++) begin
            if (c < 4) drive32(1 + c); else idle32();
            tick();
            if (out_valid32) oc.push_back(c);
        end
        check("stream_count", oc.size(), 32'd4);
        for (int j = 0; j < oc.size(); j++) check("stream_cycle", oc[j], 32'(4 + j));

        // Full table, streamed
        o0 = out_cnt32;
        for (int i = 0; i < 20; i++) begin
            drive32(i);
            tick();
        end
        idle32();
        for (int c = 0; c < 40 && exp_q32.size() != 0; c++) tick();
        check("table_count", out_cnt32 - o0, 32'd20);

        // Backpressure: output stalled for 10 cycles with input always valid
        out_ready32 = 1'b0;
        a0 = in_cnt32; o0 = out_cnt32; stable_bad = 0; held_set = 1'b0; held = '0;
        for (int c = 0; c < 10; c++) begin
            k = in_cnt32 - a0;
            drive32(5 + (k > 5 ? 5 : k));
            tick();
            if (out_valid32) begin
                if (!held_set) begin
                    held = out_data32;
                    held_set = 1'b1;
                end else if (out_data32 !== held) begin
                    stable_bad++;
                end
            end
        end
        check("bp_accepts", in_cnt32 - a0, 32'd5);
        check("bp_in_ready", {31'd0, in_ready32}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid32}, 32'd1);
        check("bp_no_output", out_cnt32 - o0, 32'd0);
        check("bp_out_stable", stable_bad, 32'd0);
        check("bp_held_data", held, vecs[5].expected);
        // A simultaneous input and output transfer on a full pipeline
        drive32(10);
        out_ready32 = 1'b1;
        tick();
        out_ready32 = 1'b0;
        idle32();
        #1;
        check("full_both_in", in_cnt32 - a0, 32'd6);
        check("full_both_out", out_cnt32 - o0, 32'd1);
        check("full_still_full", {31'd0, in_ready32}, 32'd0);
        out_ready32 = 1'b1;
        for (int c = 0; c < 40 && exp_q32.size() != 0; c++) tick();
        check("bp_drain_count", out_cnt32 - o0, 32'd6);

        // Bubble collapse under an output stall
        out_ready32 = 1'b0;
        a0 = in_cnt32; o0 = out_cnt32; ir_bad = 0;
        drive32(11); tick();
        idle32(); tick(); tick();
        drive32(12); tick();
        idle32();
        for (int c = 0; c < 6; c++) begin
            if (!in_ready32) ir_bad++;
            tick();
        end
        check("bubble_in_ready", ir_bad, 32'd0);
        check("bubble_accepts", in_cnt32 - a0, 32'd2);
        check("bubble_out_valid", {31'd0, out_valid32}, 32'd1);
        check("bubble_out_data", out_data32, vecs[11].expected);
        check("bubble_ready_left", {31'd0, in_ready32}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            drive32(13 + j);
            tick();
        end
        idle32();
        #1;
        check("bubble_full_accepts", in_cnt32 - a0, 32'd5);
        check("bubble_full_ready", {31'd0, in_ready32}, 32'd0);
        out_ready32 = 1'b1;
        for (int c = 0; c < 40 && exp_q32.size() != 0; c++) tick();
        check("bubble_drain_count", out_cnt32 - o0, 32'd5);

        // Reset with three requests in flight discards them
        for (int j = 0; j < 3; j++) begin
            drive32(16 + j);
            tick();
        end
        idle32();
        tick();
        rst = 1'b0;
        #1;
        exp_q32.delete();
        o0 = out_cnt32;
        check("midrst_out_valid", {31'd0, out_valid32}, 32'd0);
        tick();
        rst = 1'b1;
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid32) stable_bad++;
        end
        check("midrst_no_output", stable_bad, 32'd0);
        check("midrst_out_count", out_cnt32 - o0, 32'd0);

        // N=8 sweep with random handshakes
        a0 = in_cnt8; o0 = out_cnt8;
        for (int c = 0; c < 3000 && (out_cnt8 - o0) < 64; c++) begin
            k = in_cnt8 - a0;
            if (k < 64 && $urandom_range(0, 3) != 0) drive8(k);
            else in_valid8 = 1'b0;
            out_ready8 = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid8 = 1'b0;
        check("n8_count", out_cnt8 - o0, 32'd64);
        check("n8_queue_empty", exp_q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
